// File: rtl/pipe_cla_adder.sv
// ============================================================================
// Module      : pipe_cla_adder
// Description : Pipelined carry-lookahead adder/subtractor, one BLOCK-bit
//               lookahead group resolved per stage, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int L = WIDTH / BLOCK;

    // Returns {carry_out, sum}; every carry is a flat G/P product term.
    function automatic logic [BLOCK:0] cla_group(input logic [BLOCK-1:0] x,
                                                 input logic [BLOCK-1:0] y,
                                                 input logic             ci);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             t;
        g = x & y;
        p = x ^ y;
        c = '0;
        for (int i = 0; i <= BLOCK; i++) begin
            c[i] = ci;
            for (int j = 0; j < i; j++) c[i] = c[i] & p[j];
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int m = j + 1; m < i; m++) t = t & p[m];
                c[i] = c[i] | t;
            end
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    logic w_adv;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < L; k++) begin : g_stage
        // Stage k sees operand bits [WIDTH-1:k*BLOCK] and sum bits below it.
        localparam int IW = WIDTH - k * BLOCK;
        localparam int SW = (k + 1) * BLOCK;

        logic [IW-1:0]  w_opa;
        logic [IW-1:0]  w_opb;
        logic           w_ci;
        logic           w_vi;
        logic [BLOCK:0] w_grp;
        logic [SW-1:0]  w_snext;
        logic [SW-1:0]  r_s;
        logic           r_c;
        logic           r_vld;

        if (k == 0) begin : g_head
            assign w_opa   = a;
            assign w_opb   = sub ? ~b : b;
            assign w_ci    = sub ? ~cin : cin;
            assign w_vi    = in_valid;
            assign w_snext = w_grp[BLOCK-1:0];
        end else begin : g_body
            assign w_opa   = g_stage[k-1].g_fwd.r_a;
            assign w_opb   = g_stage[k-1].g_fwd.r_b;
            assign w_ci    = g_stage[k-1].r_c;
            assign w_vi    = g_stage[k-1].r_vld;
            assign w_snext = {w_grp[BLOCK-1:0], g_stage[k-1].r_s};
        end

        assign w_grp = cla_group(w_opa[BLOCK-1:0], w_opb[BLOCK-1:0], w_ci);

        // Data registers only load on a real operation so outputs hold across bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_s   <= '0;
            end else if (w_adv) begin
                r_vld <= w_vi;
                if (w_vi) begin
                    r_c <= w_grp[BLOCK];
                    r_s <= w_snext;
                end
            end
        end

        if (k < L - 1) begin : g_fwd
            logic [IW-BLOCK-1:0] r_a;
            logic [IW-BLOCK-1:0] r_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv && w_vi) begin
                    r_a <= w_opa[IW-1:BLOCK];
                    r_b <= w_opb[IW-1:BLOCK];
                end
            end
        end

        if (k == L - 1) begin : g_tail
            logic r_ovf;

            // a^b^sum at the MSB recovers the carry into the MSB.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv && w_vi) begin
                    r_ovf <= w_opa[BLOCK-1] ^ w_opb[BLOCK-1] ^ w_grp[BLOCK-1] ^ w_grp[BLOCK];
                end
            end
        end
    end

    assign out_valid = g_stage[L-1].r_vld;
    assign s         = g_stage[L-1].r_s;
    assign cout      = g_stage[L-1].r_c;
    assign ovf       = g_stage[L-1].g_tail.r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipe_cla_adder.sv
// ============================================================================
// Module      : tb_pipe_cla_adder
// Description : Randomised and directed bench for pipe_cla_adder against an
//               arithmetic reference model with an in-order result queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_cla_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int           tests = 0;
    int           fails = 0;
    int           n_out = 0;
    logic         exp_stall = 1'b0;
    logic [17:0]  q[$];

    pipe_cla_adder #(.WIDTH(W), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {ovf, cout, s} from plain wide arithmetic and the signed overflow rule.
    function automatic logic [17:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic sb);
        logic [W-1:0] yp;
        logic         c0;
        logic [W:0]   r;
        logic         v;
        yp = sb ? ~y : y;
        c0 = sb ? ~c : c;
        r  = {1'b0, x} + {1'b0, yp} + {{W{1'b0}}, c0};
        v  = (x[W-1] == yp[W-1]) && (r[W-1] != x[W-1]);
        return {v, r[W], r[W-1:0]};
    endfunction

    // One clock: drive after the falling edge, score just before the rising edge.
    task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic isub, input logic ordy, output logic acc);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = isub;
        out_ready = ordy;
        #1;
        if (exp_stall) check("stall_in_ready", in_ready, 0);
        if (out_valid) begin
            if (q.size() == 0) check("spurious_out", out_valid, 0);
            else               check("result", {ovf, cout, s}, q[0]);
        end
        if (out_valid && out_ready && q.size() > 0) begin
            void'(q.pop_front());
            n_out++;
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(ia, ib, ic, isub));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        logic acc;
        for (int n = 0; n < 40 && q.size() > 0; n++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        check(tag, q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        int   lat;
        int   sent;
        logic [W-1:0] ta [8];
        logic [W-1:0] tb [8];

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Carry ripples across all four groups; also measure latency.
        cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
        check("t2_accept", acc, 1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            lat++;
        end
        check("t2_latency", lat, 4);
        check("t2_value", {ovf, cout, s}, 18'h10000);
        drain("t2_drain");

        cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
        cycle(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, acc);
        drain("t3_drain");

        // Eight ops back to back with the consumer stalled in cycles 6..8.
        for (int i = 0; i < 8; i++) begin
            ta[i] = 16'($urandom);
            tb[i] = 16'($urandom);
        end
        sent  = 0;
        n_out = 0;
        for (int cyc = 1; cyc <= 60 && (sent < 8 || q.size() > 0); cyc++) begin
            exp_stall = (cyc >= 6 && cyc <= 8);
            if (sent < 8) cycle(1'b1, ta[sent], tb[sent], sent[0], sent[1], !exp_stall, acc);
            else          cycle(1'b0, '0, '0, 1'b0, 1'b0, !exp_stall, acc);
            if (acc) sent++;
        end
        exp_stall = 1'b0;
        check("t4_sent", sent, 8);
        check("t4_received", n_out, 8);

        // Reset with three operations in flight: none may emerge.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h1111 * i, 16'h0101, 1'b1, 1'b0, 1'b1, acc);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        #1;
        check("t5_out_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            check("t5_flushed", out_valid, 0);
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        end

        // Random traffic on both handshakes.
        n_out = 0;
        sent  = 0;
        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, acc);
            if (acc) sent++;
        end
        drain("t6_drain");
        check("t6_count", n_out, sent);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
